// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  localparam int UART_SCHED_MAX_REQ = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_LAUNCH,
    S_WAIT_ACK,
    S_WAIT_DONE
  } uart_sched_state_t;

  // Counter must be able to hold ACK_TIMEOUT itself.
  function automatic int ack_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin winner select starting at ptr; mask limits the
// eligible requesters (used by the packet lock).
module uart_rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] winner
);

  logic [N_REQ-1:0] eligible;
  int               idx;

  assign eligible = req & mask;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int off = 0; off < UART_SCHED_MAX_REQ; off++) begin
      if (off < N_REQ) begin
        idx = int'(ptr) + off;
        if (idx >= N_REQ) idx = idx - N_REQ;
        if (!found && eligible[idx]) begin
          found  = 1'b1;
          winner = IDX_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter between N_REQ producers.
// Optional packet lock enabled by defining UART_TX_SCHED_LOCK_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ        = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int ACK_TIMEOUT  = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*PAYLOAD_BITS-1:0] req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          uart_tx_en,
  output logic [PAYLOAD_BITS-1:0]       uart_tx_data,
  input  logic                          uart_tx_busy,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          sched_busy,
  output logic                          err_no_ack
);

  localparam int                CNT_W    = ack_cnt_width(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0]  ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

  uart_sched_state_t state, state_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  ptr_next;
  logic [CNT_W-1:0]  ack_cnt;
  logic [N_REQ-1:0]  arb_mask;
  logic              arb_found;
  logic [IDX_W-1:0]  arb_winner;
  logic              ptr_adv;
  logic              timeout_hit;

  uart_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req    (req_valid),
    .mask   (arb_mask),
    .ptr    (ptr),
    .found  (arb_found),
    .winner (arb_winner)
  );

  assign timeout_hit = (state == S_WAIT_ACK) && !uart_tx_busy && (ack_cnt == ACK_LAST);
  assign ptr_next    = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

`ifdef UART_TX_SCHED_LOCK_EN
  logic             lock_active;
  logic [IDX_W-1:0] lock_id;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_active <= 1'b0;
      lock_id     <= '0;
    end else if (state == S_ACCEPT) begin
      lock_active <= !req_last[grant_id];
      lock_id     <= grant_id;
    end else if (timeout_hit) begin
      lock_active <= 1'b0;
    end
  end

  always_comb begin
    arb_mask = '1;
    if (lock_active) begin
      arb_mask          = '0;
      arb_mask[lock_id] = 1'b1;
    end
  end

  // Only the closing beat of a packet moves the rotation on.
  assign ptr_adv = req_last[grant_id];
`else
  logic unused_last;

  assign unused_last = ^req_last;
  assign arb_mask    = '1;
  assign ptr_adv     = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (arb_found && !uart_tx_busy) state_nxt = S_ACCEPT;
      S_ACCEPT:    state_nxt = S_LAUNCH;
      S_LAUNCH:    state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (uart_tx_busy)              state_nxt = S_WAIT_DONE;
        else if (ack_cnt == ACK_LAST)  state_nxt = S_IDLE;
      end
      S_WAIT_DONE: if (!uart_tx_busy) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    if (state == S_ACCEPT) req_ready[grant_id] = 1'b1;
    uart_tx_en = (state == S_LAUNCH);
    sched_busy = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_id     <= '0;
      ptr          <= '0;
      uart_tx_data <= '0;
      ack_cnt      <= '0;
      err_no_ack   <= 1'b0;
    end else begin
      err_no_ack <= timeout_hit;
      if (state == S_IDLE && state_nxt == S_ACCEPT) grant_id <= arb_winner;
      if (state == S_ACCEPT) begin
        uart_tx_data <= req_data[grant_id*PAYLOAD_BITS +: PAYLOAD_BITS];
        if (ptr_adv) ptr <= ptr_next;
      end
      if (state == S_LAUNCH)                         ack_cnt <= '0;
      else if (state == S_WAIT_ACK && !uart_tx_busy) ack_cnt <= ack_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a simple transmitter model
// (busy rises one cycle after en and stays high for 20 cycles).
module tb_uart_tx_scheduler;

  localparam int N_REQ = 4;
  localparam int PB    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_REQ-1:0]  req_valid = '0;
  logic [N_REQ*PB-1:0] req_data = '0;
  logic [N_REQ-1:0]  req_last = '0;
  logic [N_REQ-1:0]  req_ready;
  logic              uart_tx_en;
  logic [PB-1:0]     uart_tx_data;
  logic              uart_tx_busy;
  logic [1:0]        grant_id;
  logic              sched_busy;
  logic              err_no_ack;

  int checks = 0;
  int errors = 0;

  int busy_cnt = 0;
  bit model_on = 1'b1;
  bit force_busy = 1'b0;

  logic [7:0] sent[$];
  int rdy_cnt[N_REQ] = '{default: 0};
  int err_cnt = 0;
  int hot_bad = 0;

  uart_tx_scheduler #(.N_REQ(N_REQ), .PAYLOAD_BITS(PB), .ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .grant_id     (grant_id),
    .sched_busy   (sched_busy),
    .err_no_ack   (err_no_ack)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (uart_tx_en && model_on) busy_cnt <= 20;
    else if (busy_cnt > 0)      busy_cnt <= busy_cnt - 1;
  end
  assign uart_tx_busy = (busy_cnt != 0) || force_busy;

  always @(posedge clk) begin
    if (uart_tx_en) sent.push_back(uart_tx_data);
    for (int i = 0; i < N_REQ; i++) if (req_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
    if (err_no_ack) err_cnt <= err_cnt + 1;
    if (!$onehot0(req_ready)) hot_bad <= hot_bad + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0; req_valid = '0; req_last = '0; req_data = '0;
    force_busy = 1'b0; model_on = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 100 && (sched_busy || uart_tx_busy); n++) tick();
    checks++;
    if (sched_busy || uart_tx_busy) begin
      errors++; $display("FAIL idle_timeout: sched_busy=%b tx_busy=%b want 0 0", sched_busy, uart_tx_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
    checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", uart_tx_en); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", uart_tx_data); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
    checks++; if (sched_busy !== 1'b0 || err_no_ack !== 1'b0) begin
      errors++; $display("FAIL rst_busy_err: got %b%b want 00", sched_busy, err_no_ack);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    reset_dut();
    req_data[23:16] = 8'hA5; req_valid = 4'b0100;
    tick();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL single_grant: got %0d want 2", grant_id); end
    checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL single_en_early: got %b want 0", uart_tx_en); end
    tick();
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'hA5) begin
      errors++; $display("FAIL single_launch: got en=%b data=%h want en=1 data=a5", uart_tx_en, uart_tx_data);
    end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_ready_len: got %b want 0000", req_ready); end
    req_valid = '0;
    for (int n = 0; n < 10 && !uart_tx_busy; n++) tick();
    for (int n = 0; n < 50 && uart_tx_busy; n++) tick();
    checks++; if (uart_tx_busy !== 1'b0 || sched_busy !== 1'b1) begin
      errors++; $display("FAIL single_done_hold: got tx_busy=%b sched_busy=%b want 0 1", uart_tx_busy, sched_busy);
    end
    tick();
    checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL single_done_fall: got %b want 0", sched_busy); end
  endtask

  task automatic test_round_robin();
    int base;
    int snap[N_REQ];
    int hot0;
    reset_dut();
    base = sent.size();
    snap = rdy_cnt;
    hot0 = hot_bad;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_valid = 4'b1111;
    for (int n = 0; n < 400 && sent.size() < base + 5; n++) tick();
    req_valid = '0;
    checks++;
    if (sent.size() < base + 5) begin
      errors++; $display("FAIL rr_count: got %0d bytes want 5", sent.size() - base);
    end else begin
      for (int k = 0; k < 5; k++) begin
        logic [7:0] exp;
        exp = 8'h10 + 8'(k % 4);
        checks++;
        if (sent[base+k] !== exp) begin errors++; $display("FAIL rr_byte%0d: got %h want %h", k, sent[base+k], exp); end
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      checks++;
      if (rdy_cnt[i] - snap[i] !== ((i == 0) ? 2 : 1)) begin
        errors++; $display("FAIL rr_ready%0d: got %0d pulses want %0d", i, rdy_cnt[i] - snap[i], (i == 0) ? 2 : 1);
      end
    end
    checks++; if (hot_bad !== hot0) begin errors++; $display("FAIL rr_onehot: got %0d bad cycles want 0", hot_bad - hot0); end
    wait_idle();
  endtask

  task automatic test_busy_block();
    int snap;
    reset_dut();
    force_busy = 1'b1;
    req_data[15:8] = 8'h3C; req_valid = 4'b0010;
    snap = rdy_cnt[1];
    repeat (10) tick();
    checks++; if (rdy_cnt[1] !== snap || sched_busy !== 1'b0) begin
      errors++; $display("FAIL busy_block: got ready_pulses=%0d sched_busy=%b want 0 0", rdy_cnt[1] - snap, sched_busy);
    end
    force_busy = 1'b0;
    tick();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL busy_grant: got %b want 0010", req_ready); end
    tick();
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h3C) begin
      errors++; $display("FAIL busy_launch: got en=%b data=%h want en=1 data=3c", uart_tx_en, uart_tx_data);
    end
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_no_ack();
    int snap;
    reset_dut();
    model_on = 1'b0;
    snap = err_cnt;
    req_data[31:24] = 8'h77; req_valid = 4'b1000;
    tick();
    tick();
    checks++; if (uart_tx_en !== 1'b1) begin errors++; $display("FAIL noack_launch: got %b want 1", uart_tx_en); end
    req_valid = '0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (err_no_ack !== (k == 4)) begin errors++; $display("FAIL noack_err_c%0d: got %b want %b", k, err_no_ack, (k == 4)); end
      if (k == 4) begin
        checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL noack_idle: got %b want 0", sched_busy); end
      end
    end
    checks++; if (err_cnt - snap !== 1) begin errors++; $display("FAIL noack_pulses: got %0d want 1", err_cnt - snap); end
    model_on = 1'b1;
    req_data[7:0] = 8'h5A; req_valid = 4'b0001;
    for (int n = 0; n < 20 && !uart_tx_en; n++) tick();
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h5A || grant_id !== 2'd0) begin
      errors++; $display("FAIL noack_next: got en=%b data=%h grant=%0d want 1 5a 0", uart_tx_en, uart_tx_data, grant_id);
    end
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int snap;
    reset_dut();
    req_data[15:8] = 8'h99; req_valid = 4'b0010;
    for (int n = 0; n < 20 && !uart_tx_en; n++) tick();
    req_data[15:8] = 8'h42;
    repeat (3) tick();
    checks++; if (sched_busy !== 1'b1 || uart_tx_busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got sched_busy=%b tx_busy=%b want 1 1", sched_busy, uart_tx_busy);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (sched_busy !== 1'b0 || grant_id !== 2'd0 || uart_tx_data !== 8'h00) begin
      errors++; $display("FAIL mid_async: got busy=%b grant=%0d data=%h want 0 0 00", sched_busy, grant_id, uart_tx_data);
    end
    checks++; if (req_ready !== 4'b0 || uart_tx_en !== 1'b0 || err_no_ack !== 1'b0) begin
      errors++; $display("FAIL mid_async_ctl: got ready=%b en=%b err=%b want 0000 0 0", req_ready, uart_tx_en, err_no_ack);
    end
    tick();
    tick();
    rst = 1'b1;
    snap = rdy_cnt[1];
    for (int n = 0; n < 40 && uart_tx_busy; n++) tick();
    checks++; if (rdy_cnt[1] !== snap || sched_busy !== 1'b0) begin
      errors++; $display("FAIL mid_hold: got ready_pulses=%0d sched_busy=%b want 0 0", rdy_cnt[1] - snap, sched_busy);
    end
    tick();
    checks++; if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin
      errors++; $display("FAIL mid_regrant: got ready=%b grant=%0d want 0010 1", req_ready, grant_id);
    end
    tick();
    checks++; if (uart_tx_en !== 1'b1 || uart_tx_data !== 8'h42) begin
      errors++; $display("FAIL mid_launch: got en=%b data=%h want 1 42", uart_tx_en, uart_tx_data);
    end
    req_valid = '0;
    wait_idle();
  endtask

  task automatic test_lock();
    int base;
    int seq;
    bit adv;
    bit r0_on;
    logic [7:0] exp[4];
`ifdef UART_TX_SCHED_LOCK_EN
    exp = '{8'hC1, 8'hC2, 8'hC3, 8'hB0};
`else
    exp = '{8'hC1, 8'hB0, 8'hC2, 8'hB0};
`endif
    reset_dut();
    base = sent.size();
    seq = 0; adv = 1'b0; r0_on = 1'b0;
    req_data[15:8] = 8'hC1; req_last = '0; req_valid = 4'b0010;
    for (int n = 0; n < 400 && sent.size() < base + 4; n++) begin
      tick();
      if (adv) begin
        adv = 1'b0;
        seq++;
        if (seq < 3) begin
          req_data[15:8] = 8'hC1 + 8'(seq);
          req_last[1] = (seq == 2);
        end else begin
          req_valid[1] = 1'b0;
          req_last[1] = 1'b0;
        end
      end
      if (req_ready[1]) begin
        adv = 1'b1;
        if (!r0_on) begin
          r0_on = 1'b1;
          req_data[7:0] = 8'hB0;
          req_valid[0] = 1'b1;
        end
      end
    end
    req_valid = '0; req_last = '0;
    checks++;
    if (sent.size() < base + 4) begin
      errors++; $display("FAIL lock_count: got %0d bytes want 4", sent.size() - base);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (sent[base+k] !== exp[k]) begin errors++; $display("FAIL lock_byte%0d: got %h want %h", k, sent[base+k], exp[k]); end
      end
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_block();
    test_no_ack();
    test_reset_mid();
    test_lock();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares one UART transmitter between `N_REQ` byte producers. Each requester offers bytes over a valid/ready handshake. The scheduler grants one requester, captures its byte, and launches it into the transmitter with a single-cycle `uart_tx_en` pulse. It then tracks `uart_tx_busy` until the frame is complete before granting again. It sits between the system byte sources and the transmitter instance in the top level, and runs on the transmitter's clock.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `PAYLOAD_BITS`, default 8: byte width; must match the transmitter.
- `ACK_TIMEOUT`, default 4: cycles allowed after launch for `uart_tx_busy` to rise.
- `clk` in, 1: single clock, same clock as the transmitter.
- `rst` in, 1: reset; asynchronous, active-low.
- `req_valid` in, `N_REQ`: requester i has a byte.
- `req_data` in, `N_REQ*PAYLOAD_BITS`: byte i at bits `[i*PAYLOAD_BITS +: PAYLOAD_BITS]`; held stable while valid and not ready.
- `req_last` in, `N_REQ`: last byte of a packet; used only with the lock feature.
- `req_ready` out, `N_REQ`: one-hot accept pulse.
- `uart_tx_en` out, 1: launch pulse to the transmitter.
- `uart_tx_data` out, `PAYLOAD_BITS`: byte to the transmitter.
- `uart_tx_busy` in, 1: transmitter busy.
- `grant_id` out, `$clog2(N_REQ)`: index of the current or last grant.
- `sched_busy` out, 1: high in every state except IDLE.
- `err_no_ack` out, 1: one-cycle pulse when the transmitter never acknowledged a launch.

## Operation
- FSM states: IDLE, ACCEPT, LAUNCH, WAIT_ACK, WAIT_DONE.
- **IDLE**: if any eligible `req_valid` and `!uart_tx_busy`:
  - register the round-robin winner into `grant_id`;
  - go to ACCEPT.
- **ACCEPT**:
  - `req_ready[grant_id]`=1 for exactly this cycle;
  - capture the byte into `uart_tx_data`;
  - advance the rotate pointer to `grant_id+1` (mod `N_REQ`);
  - go to LAUNCH.
- **LAUNCH**: `uart_tx_en`=1 for exactly this cycle; clear the ack counter; go to WAIT_ACK.
- **WAIT_ACK**:
  - `uart_tx_busy`=1 goes to WAIT_DONE.
  - Otherwise the counter increments. When it reaches `ACK_TIMEOUT`, pulse `err_no_ack` and go to IDLE; the byte is dropped.
- **WAIT_DONE**: `uart_tx_busy`=0 goes to IDLE.
- **Round-robin**:
  - Search starts at the pointer and wraps from `N_REQ-1` to 0.
  - The pointer resets to 0, so requester 0 wins first.
  - A requester that deasserts valid before ACCEPT is not accepted. Arbitration is done only in IDLE, and the grant is not revoked.
- `uart_tx_data` holds its value until the next ACCEPT.
- **Reset**: all outputs 0, pointer 0, state IDLE. Reset mid-frame aborts tracking; the IDLE busy check prevents launching over a frame still shifting out.

## Timing
- Valid sampled high in IDLE at edge t:
  - `req_ready` is high in cycle t+1;
  - `uart_tx_en` is high in cycle t+2.
- Minimum spacing between grants is frame length + 4 cycles.
- All outputs are registered; there is no combinational path from `req_*` to `uart_tx_*`.
- A requester must not change `req_data` between asserting valid and seeing ready.

## Configuration
- Macro: `UART_TX_SCHED_LOCK_EN`.
- **Defined**: packet lock.
  - A byte accepted with `req_last`=0 locks the grant to that requester.
  - While locked, IDLE considers only that requester's valid; other requesters stall.
  - Accepting a byte with `req_last`=1 releases the lock and advances the pointer.
  - The pointer does not advance on non-last beats.
  - A timeout while locked also releases the lock.
- **Undefined**: `req_last` is ignored, and every byte is arbitrated independently.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_sched_state_t`;
  - `UART_SCHED_MAX_REQ` = 8;
  - ack-counter width function.
- One sub-module, `uart_rr_arbiter`: combinational pointer-based round-robin winner select over an `N_REQ` request vector, with a mask input used for the lock.

## Test plan
Bench settings: `N_REQ`=4, `PAYLOAD_BITS`=8, transmitter model raises busy 1 cycle after en and holds it 20 cycles.

1. Single request: requester 2 valid with 0xA5 -> `req_ready[2]` pulses at t+1, `uart_tx_en` with 0xA5 at t+2, `grant_id`=2, `sched_busy` falls 1 cycle after busy falls.
2. All four requesters valid continuously with 0x10..0x13 -> transmitted order 0x10, 0x11, 0x12, 0x13, 0x10; exactly one `req_ready` pulse per byte.
3. Busy already high when a request arrives -> no `req_ready` until busy low; then a normal grant.
4. Transmitter model never raises busy -> `err_no_ack` pulses once, exactly 4 cycles after the WAIT_ACK entry; next request is served normally.
5. Reset asserted in WAIT_DONE while busy is high -> all outputs 0 asynchronously; after release, no launch until busy low.
6. With `UART_TX_SCHED_LOCK_EN`: requester 1 sends 3 bytes (last on the third) while requester 0 is valid -> bytes 1a, 1b, 1c are sent contiguously, then requester 0. Without the macro -> requesters interleave as 1a, 0, 1b.
